// File: rtl/ntt_seq_ctrl.sv
// NTT sequencing controller: loads coefficient pairs from two input FIFOs into the
// core, pulses start, waits for completion, then drains results pairwise to an
// output FIFO through a one-entry hold register.
module ntt_seq_ctrl #(
  parameter int unsigned N_PAIRS = 128,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic              in_empty_a,
  input  logic              in_empty_b,
  output logic              in_rdreq,
  input  logic [31:0]       in_data_a,
  input  logic [31:0]       in_data_b,
  output logic              core_we,
  output logic              core_start,
  output logic              core_mode,
  output logic [ADDR_W-1:0] core_addr_a,
  output logic [ADDR_W-1:0] core_addr_b,
  output logic [DATA_W-1:0] core_din_a,
  output logic [DATA_W-1:0] core_din_b,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout_a,
  input  logic [DATA_W-1:0] core_dout_b,
  input  logic              out_full,
  output logic              out_wrreq,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  localparam int unsigned K_W   = ADDR_W - 1;
  localparam int unsigned CNT_W = ADDR_W;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_PAIRS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAIRS - 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(N_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  logic              r_err;
  logic [K_W-1:0]    r_k;        // pair index: writes done in LOAD, next read in DRAIN
  logic [CNT_W-1:0]  r_cnt;      // FIFO reads (LOAD) or core reads (DRAIN) issued
  logic [CNT_W-1:0]  r_ocnt;     // output words written
  logic              r_rd_pend;  // input FIFO data valid this cycle
  logic              r_dv;       // core read data valid this cycle
  logic              r_hold_v;
  logic [31:0]       r_hold;
  logic              w_issue;
  logic              w_bad;
  logic              w_unused_in;

  assign core_mode   = r_mode;
  assign addr_err    = r_err;
  assign w_unused_in = ^{in_data_a[31:24], in_data_b[31:24]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-state strobes
  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    core_start  = 1'b0;
    in_rdreq    = 1'b0;
    core_we     = 1'b0;
    core_addr_a = '0;
    core_addr_b = '0;
    core_din_a  = '0;
    core_din_b  = '0;
    w_issue     = 1'b0;
    w_bad       = 1'b0;
    out_wrreq   = 1'b0;
    out_data    = r_hold_v ? r_hold : 32'({core_dout_b, core_dout_a});
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        in_rdreq = !in_empty_a && !in_empty_b && (r_cnt < N_CNT);
        if (r_rd_pend) begin
          core_we     = 1'b1;
          core_addr_a = in_data_a[16 +: ADDR_W];
          core_addr_b = in_data_b[16 +: ADDR_W];
          core_din_a  = in_data_a[DATA_W-1:0];
          core_din_b  = in_data_b[DATA_W-1:0];
          w_bad = (in_data_a[16 +: ADDR_W] != {r_k, 1'b0}) ||
                  (in_data_b[16 +: ADDR_W] != {r_k, 1'b1});
          if (r_k == LAST_K) w_next = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        core_addr_a = {r_k, 1'b0};
        core_addr_b = {r_k, 1'b1};
        // no read may land while the hold register is (or is about to be) occupied
        w_issue   = (r_cnt < N_CNT) && !r_hold_v && !(r_dv && out_full);
        out_wrreq = !out_full && (r_hold_v || r_dv);
        if (out_wrreq && (r_ocnt == LAST_CNT)) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, pipeline flags, hold register and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 1'b0;
      r_err     <= 1'b0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_ocnt    <= '0;
      r_rd_pend <= 1'b0;
      r_dv      <= 1'b0;
      r_hold_v  <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_rd_pend <= in_rdreq;
      r_dv      <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_mode   <= cmd_mode;
            r_err    <= 1'b0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_ocnt   <= '0;
            r_hold_v <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_rdreq) r_cnt <= r_cnt + CNT_W'(1);
          if (r_rd_pend) begin
            if (w_bad) r_err <= 1'b1;
            if (r_k != LAST_K) r_k <= r_k + K_W'(1);
          end
        end
        S_WAIT: begin
          if (core_done) begin
            r_k   <= '0;
            r_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (w_issue) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_k != LAST_K) r_k <= r_k + K_W'(1);
          end
          if (out_wrreq) r_ocnt <= r_ocnt + CNT_W'(1);
          if (r_hold_v) begin
            if (!out_full) r_hold_v <= 1'b0;
          end else if (r_dv && out_full) begin
            r_hold_v <= 1'b1;
            r_hold   <= 32'({core_dout_b, core_dout_a});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Scoreboard bench for ntt_seq_ctrl: stimulus pushes expected core writes, output
// words and scalar checks; a negedge monitor pops and compares on DUT activity.
module tb_ntt_seq_ctrl;
  localparam int unsigned NP = 128;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid = 1'b0, cmd_mode = 1'b0, cmd_ready;
  logic          in_empty_a, in_empty_b, in_rdreq;
  logic [31:0]   in_data_a = '0, in_data_b = '0;
  logic          core_we, core_start, core_mode;
  logic [AW-1:0] core_addr_a, core_addr_b;
  logic [DW-1:0] core_din_a, core_din_b;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_dout_a = '0, core_dout_b = '0;
  logic          out_full = 1'b0, out_wrreq;
  logic [31:0]   out_data;
  logic          busy, done, addr_err;

  always #5 clk = ~clk;

  ntt_seq_ctrl #(.N_PAIRS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .in_empty_a(in_empty_a), .in_empty_b(in_empty_b), .in_rdreq(in_rdreq),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .core_we(core_we), .core_start(core_start), .core_mode(core_mode),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
    .core_din_a(core_din_a), .core_din_b(core_din_b),
    .core_done(core_done), .core_dout_a(core_dout_a), .core_dout_b(core_dout_b),
    .out_full(out_full), .out_wrreq(out_wrreq), .out_data(out_data),
    .busy(busy), .done(done), .addr_err(addr_err)
  );

  typedef struct {
    string       tag;
    logic [47:0] act;
    logic [47:0] exp;
  } chk_t;

  chk_t        q_chk[$];
  logic [47:0] q_wr[$];
  logic [31:0] q_out[$];
  int          checks = 0, failures = 0;
  int          n_start = 0, n_done = 0, n_owr = 0, n_cwr = 0;
  logic        exp_mode = 1'b0;
  logic [DW-1:0] mem_exp [256];

  // Input FIFO model: vectors appended by stimulus, consumed on in_rdreq
  logic [31:0] va [NP*8];
  logic [31:0] vb [NP*8];
  int ia = 0, ib = 0, nvec = 0;
  int stall_at = -1, stall_cnt = 0;
  assign in_empty_a = (ia >= nvec);
  assign in_empty_b = (ib >= nvec) || (stall_cnt != 0);

  always @(posedge clk) begin
    if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    if (in_rdreq && ia < nvec && ib < nvec) begin
      in_data_a <= va[ia];
      in_data_b <= vb[ib];
      ia <= ia + 1;
      ib <= ib + 1;
      if (ib + 1 == stall_at) stall_cnt <= 10;
    end
  end

  // Core model: dual-port memory, read data one cycle after address
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (core_we) begin
      mem[core_addr_a] <= core_din_a;
      mem[core_addr_b] <= core_din_b;
    end
    core_dout_a <= mem[core_addr_a];
    core_dout_b <= mem[core_addr_b];
  end

  // Output FIFO full flag: optionally toggles every 3 cycles
  logic full_tog = 1'b0;
  int   fdiv = 0;
  always @(posedge clk) begin
    if (full_tog) begin
      if (fdiv == 2) begin
        fdiv     <= 0;
        out_full <= ~out_full;
      end else fdiv <= fdiv + 1;
    end else begin
      fdiv     <= 0;
      out_full <= 1'b0;
    end
  end

  task automatic cmp(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: drains scalar checks and compares every DUT transaction
  always @(negedge clk) begin
    chk_t        c;
    logic [47:0] e;
    while (q_chk.size() != 0) begin
      c = q_chk.pop_front();
      cmp(c.tag, c.act, c.exp);
    end
    if (in_rdreq) cmp("rdreq_when_empty", 48'({in_empty_a, in_empty_b}), 48'd0);
    if (busy) cmp("ready_while_busy", 48'(cmd_ready), 48'd0);
    if (core_we) begin
      n_cwr++;
      cmp("core_wr_expected", 48'(q_wr.size() != 0), 48'd1);
      if (q_wr.size() != 0) begin
        e = q_wr.pop_front();
        cmp("core_wr", {core_addr_a, core_din_a, core_addr_b, core_din_b}, e);
      end
    end
    if (out_wrreq) begin
      cmp("wr_while_full", 48'(out_full), 48'd0);
      if (!out_full) begin
        n_owr++;
        cmp("out_expected", 48'(q_out.size() != 0), 48'd1);
        if (q_out.size() != 0) cmp("out_word", 48'(out_data), 48'(q_out.pop_front()));
      end
    end
    if (core_start) begin
      n_start++;
      cmp("start_mode", 48'(core_mode), 48'(exp_mode));
    end
    if (done) n_done++;
  end

  task automatic push_chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    chk_t c;
    c.tag = tag;
    c.act = act;
    c.exp = exp;
    q_chk.push_back(c);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] reset_view();
    return {cmd_ready, busy, done, addr_err, in_rdreq, out_wrreq, core_we, core_start, core_mode};
  endfunction

  // One transform: queue vectors, issue command, optionally complete and drain
  task automatic run_cmd(input logic mode, input int seed, input int bad_pair, input int st_at,
                         input bit tog, input bit finish_it, input bit nuisance, input bit exp_err);
    int s0, d0, o0, c0;
    logic [7:0]  aa, ab;
    logic [15:0] da, db;
    for (int p = 0; p < NP; p++) begin
      aa = 8'(2 * p);
      ab = 8'(2 * p + 1);
      if (p == bad_pair) aa = 8'h20;
      da = 16'((seed << 12) | (2 * p));
      db = 16'((seed << 12) | 16'h0800 | (2 * p + 1));
      va[nvec + p] = {8'h00, aa, da};
      vb[nvec + p] = {8'h00, ab, db};
      q_wr.push_back({aa, da, ab, db});
      mem_exp[aa] = da;
      mem_exp[ab] = db;
    end
    stall_at = (st_at >= 0) ? nvec + st_at : -1;
    exp_mode = mode;
    s0 = n_start; d0 = n_done; o0 = n_owr; c0 = n_cwr;
    nvec = nvec + NP;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cyc(1);
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    push_chk("busy_after_cmd", 48'(busy), 48'd1);
    push_chk("err_cleared", 48'(addr_err), 48'd0);
    if (nuisance) begin
      cyc(20);
      cmd_valid = 1'b1;
      cmd_mode  = ~mode;
      core_done = 1'b1;
      cyc(1);
      core_done = 1'b0;
      cyc(2);
      cmd_valid = 1'b0;
      cmd_mode  = 1'b0;
    end
    for (int t = 0; t < 3000 && n_start == s0; t++) cyc(1);
    push_chk("start_seen", 48'(n_start - s0), 48'd1);
    if (!finish_it) return;
    full_tog = tog;
    cyc(4);
    push_chk("start_once", 48'(n_start - s0), 48'd1);
    for (int k = 0; k < NP; k++) q_out.push_back({mem_exp[8'(2 * k + 1)], mem_exp[8'(2 * k)]});
    core_done = 1'b1;
    cyc(1);
    core_done = 1'b0;
    for (int t = 0; t < 3000 && n_done == d0; t++) cyc(1);
    cyc(3);
    full_tog = 1'b0;
    push_chk("core_wr_count", 48'(n_cwr - c0), 48'(NP));
    push_chk("out_wr_count", 48'(n_owr - o0), 48'(NP));
    push_chk("done_once", 48'(n_done - d0), 48'd1);
    push_chk("out_left", 48'(q_out.size()), 48'd0);
    push_chk("addr_err", 48'(addr_err), 48'(exp_err));
    push_chk("idle_after", 48'(busy), 48'd0);
  endtask

  initial begin
    int s4, d4;
    rst_n = 1'b0;
    cyc(3);
    push_chk("reset_outputs", 48'(reset_view()), 48'(9'b1_0000_0000));
    rst_n = 1'b1;
    cyc(2);
    push_chk("ready_after_reset", 48'(cmd_ready), 48'd1);

    // ordered pairs, forward mode
    run_cmd(1'b0, 1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    // FIFO B empty for 10 cycles at pair 50
    run_cmd(1'b0, 2, -1, 50, 1'b0, 1'b1, 1'b0, 1'b0);
    // pair 7 A carries address 0x20
    run_cmd(1'b0, 3, 7, -1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(5);
    push_chk("err_held_idle", 48'(addr_err), 48'd1);
    // output FIFO full toggling, inverse mode; addr_err cleared by this cmd
    run_cmd(1'b1, 6, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0);

    // reset during WAIT, then a clean inverse transform
    s4 = n_start;
    d4 = n_done;
    run_cmd(1'b1, 4, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3);
    rst_n = 1'b0;
    #1;
    push_chk("reset_in_wait", 48'(reset_view()), 48'(9'b1_0000_0000));
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    push_chk("no_done_after_abort", 48'(n_done - d4), 48'd0);
    push_chk("wr_queue_empty", 48'(q_wr.size()), 48'd0);
    run_cmd(1'b1, 5, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    push_chk("starts_total", 48'(n_start - s4), 48'd2);
    push_chk("dones_total", 48'(n_done - d4), 48'd1);

    // busy cmd_valid and stray core_done during LOAD
    run_cmd(1'b0, 7, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0);

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_seq_ctrl.md
NTT_SEQ_CTRL -- requirements
Module: ntt_seq_ctrl

Interface
REQ-001 SHALL have parameter N_PAIRS, default 128, meaning coefficient pairs per transform (256 points).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning core coefficient address width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning coefficient width.
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid / cmd_ready / cmd_mode  in / out / in  1 / 1 / 1  transform request handshake; cmd_mode: 0 = forward, 1 = inverse.
REQ-007 in_empty_a, in_empty_b  in  1  input FIFO A/B empty flags.
REQ-008 in_rdreq  out  1  common read request to both input FIFOs.
REQ-009 in_data_a, in_data_b  in  32  FIFO words: [23:16] = address, [15:0] = coefficient; valid the cycle after in_rdreq.
REQ-010 core_we, core_start, core_mode  out  1  core write enable, start strobe, mode.
REQ-011 core_addr_a, core_addr_b  out  ADDR_W  core write or read addresses.
REQ-012 core_din_a, core_din_b  out  DATA_W  core write data.
REQ-013 core_done  in  1  core calculation complete (level or pulse).
REQ-014 core_dout_a, core_dout_b  in  DATA_W  core read data, valid the cycle after the address is driven.
REQ-015 out_full / out_wrreq / out_data  in / out / out  1 / 1 / 32  output FIFO; out_data = {dout_b, dout_a}.
REQ-016 busy / done / addr_err  out  1  not-IDLE / one-cycle completion pulse / sticky address mismatch.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, START, WAIT, DRAIN, FIN.
REQ-018 IDLE: cmd_ready = 1; on cmd_valid, latch cmd_mode, clear the pair counter k and addr_err, then go to LOAD.
REQ-019 LOAD: in_rdreq SHALL be 1 only when both empty flags are 0 and fewer than N_PAIRS reads have been issued.
REQ-020 Cycle after each read: core_we = 1, core_addr_a/b = in_data_a/b[23:16], core_din_a/b = in_data_a/b[15:0], and k increments.
REQ-021 addr_err SHALL set if in_data_a[23:16] != 2k or in_data_b[23:16] != 2k+1; the write still uses the received address.
REQ-022 After the N_PAIRS-th write, go to START with no gap cycle.
REQ-023 START: core_start = 1 for exactly one cycle and core_mode = latched mode, then go to WAIT.
REQ-024 core_mode SHALL hold the latched value from START through FIN.
REQ-025 WAIT: on core_done = 1, clear k and go to DRAIN; a core_done pulse in any other state SHALL be ignored.
REQ-026 DRAIN: drive read addresses core_addr_a = 2k, core_addr_b = 2k+1; core_we = 0.
REQ-027 DRAIN: a one-entry hold register SHALL capture data whose cycle coincides with out_full = 1.
REQ-028 DRAIN: out_wrreq = 1 only when out_full = 0 and a word is available; no word may be lost or duplicated.
REQ-029 DRAIN: throughput SHALL be one pair per cycle while out_full = 0; a new read SHALL not issue while the hold register is occupied.
REQ-030 After N_PAIRS words are written, go to FIN; FIN: done = 1 for one cycle, then go to IDLE.
REQ-031 Counter arithmetic: k is ADDR_W-1 bits and SHALL not wrap mid-phase; address 2k+1 is formed from {k,1'b1}.
REQ-032 cmd_valid while busy SHALL be ignored, with cmd_ready = 0.
REQ-033 An empty input FIFO mid-LOAD SHALL stall the load without error, for any duration.

Reset
REQ-034 rst_n = 0 SHALL force IDLE asynchronously.
REQ-035 Reset values: all strobes and counters 0, addr_err 0, hold register empty, cmd_ready 1 after release.
REQ-036 Reset mid-operation SHALL abandon the transform; no done pulse and no further FIFO or core activity.

Verification
REQ-037 128 ordered pairs, mode 0, out_full = 0 -> 128 core writes, 1 start pulse, 128 out writes {dout(2k+1), dout(2k)}, done 1 cycle, addr_err 0.
REQ-038 Input FIFO B empty for 10 cycles at pair 50 -> in_rdreq low 10 cycles, total writes still 128, no error.
REQ-039 Pair 7 A carries address 0x20 -> addr_err = 1 held until the next cmd, core written at 0x20.
REQ-040 out_full toggling every 3 cycles in DRAIN -> exactly 128 out writes, no loss or duplicates, none while full.
REQ-041 rst_n low during WAIT, then new cmd with mode 1 -> clean restart, core_mode = 1, only the second done pulse appears.
REQ-042 cmd_valid while busy and a stray core_done during LOAD -> both ignored, sequence unchanged.
